tage_history_unit: RTL and testbench

Speculative global-history and folded-history generator for the TAGE direction predictor. It sits directly upstream of the TAGE tables in fetch. Each cycle it supplies the current GHR and per-table folded index/tag registers. It checkpoints those values for every in-flight conditional branch, presents the oldest checkpoint as the feedback-side (`*_FEED`) values at resolution, and restores history on a misprediction.

---
 rtl/tage_history_unit_if.sv | 43 ++++
 rtl/tage_history_unit.sv | 166 ++++++++++++++++
 tb/tb_tage_history_unit.sv | 225 ++++++++++++++++++++++
 3 files changed

// File: rtl/tage_history_unit_if.sv
// Handshake and history bus between fetch-side TAGE logic and
// the speculative history unit.
interface tage_history_unit_if #(
  parameter int TABLE_NUM   = 4,
  parameter int GHR_LEN     = 64,
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = 9,
  parameter int ADDR_WIDTH  = 32
);
  logic                               i_pred_valid;
  logic                               i_pred_outcome;
  logic [ADDR_WIDTH-1:0]              i_pred_pc;
  logic                               o_pred_ready;
  logic [GHR_LEN-1:0]                 o_ghr;
  logic [TABLE_NUM*INDEX_WIDTH-1:0]   o_csr_idx;
  logic [TABLE_NUM*TAG_WIDTH-1:0]     o_csr_tag;
  logic [TABLE_NUM*(TAG_WIDTH-1)-1:0] o_csr_tag2;
  logic                               i_fb_valid;
  logic                               i_fb_outcome;
  logic                               i_fb_mispredict;
  logic                               o_fb_head_valid;
  logic [TABLE_NUM*INDEX_WIDTH-1:0]   o_csr_idx_feed;
  logic [TABLE_NUM*TAG_WIDTH-1:0]     o_csr_tag_feed;
  logic [TABLE_NUM*(TAG_WIDTH-1)-1:0] o_csr_tag2_feed;

  modport slave (
    input  i_pred_valid, i_pred_outcome, i_pred_pc,
    input  i_fb_valid, i_fb_outcome, i_fb_mispredict,
    output o_pred_ready, o_ghr,
    output o_csr_idx, o_csr_tag, o_csr_tag2,
    output o_fb_head_valid,
    output o_csr_idx_feed, o_csr_tag_feed, o_csr_tag2_feed
  );

  modport master (
    output i_pred_valid, i_pred_outcome, i_pred_pc,
    output i_fb_valid, i_fb_outcome, i_fb_mispredict,
    input  o_pred_ready, o_ghr,
    input  o_csr_idx, o_csr_tag, o_csr_tag2,
    input  o_fb_head_valid,
    input  o_csr_idx_feed, o_csr_tag_feed, o_csr_tag2_feed
  );
endinterface

// File: rtl/tage_history_unit.sv
// Speculative GHR + folded histories with per-branch checkpoints.
// Optional path history: define TAGE_PATH_HIST_EN.
module tage_history_unit #(
  parameter int TABLE_NUM   = 4,
  parameter int GHR_LEN     = 64,
  parameter int MIN_HIST    = 8,
  parameter int INDEX_WIDTH = 10,
  parameter int TAG_WIDTH   = 9,
  parameter int DEPTH       = 8,
  parameter int ADDR_WIDTH  = 32
) (
  input logic clk,
  input logic rst_n,
  tage_history_unit_if.slave bus
);
  localparam int IW  = INDEX_WIDTH;
  localparam int TW  = TAG_WIDTH;
  localparam int T2W = TAG_WIDTH - 1;
  localparam int IB  = TABLE_NUM * IW;
  localparam int TB  = TABLE_NUM * TW;
  localparam int T2B = TABLE_NUM * T2W;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  typedef struct packed {
    logic [GHR_LEN-1:0] ghr;
    logic [IB-1:0]      idx;
    logic [TB-1:0]      tag;
    logic [T2B-1:0]     tag2;
`ifdef TAGE_PATH_HIST_EN
    logic [15:0]        phist;
`endif
  } hist_t;

  hist_t         cur_q, cur_d;
  hist_t         mem_q [DEPTH];
  hist_t         head;
  logic [PW-1:0] wr_q, wr_d;
  logic [PW-1:0] rd_q, rd_d;
  logic [PW:0]   cnt_q, cnt_d;
  logic          head_valid, ready;
  logic          fb_any, mis, pop, push;
  logic          unused_pc;

`ifdef TAGE_PATH_HIST_EN
  logic          pcb_q [DEPTH];
`endif

  // Rotate each fold, inject the new bit, retire the bit leaving L_g.
  function automatic hist_t shift_in(hist_t s, logic b);
    hist_t          r;
    logic [IW-1:0]  ci;
    logic [TW-1:0]  ct;
    logic [T2W-1:0] c2;
    int             l;
    r = s;
    r.ghr = {s.ghr[GHR_LEN-2:0], b};
    for (int g = 0; g < TABLE_NUM; g++) begin
      l = MIN_HIST << g;
      ci = s.idx[g*IW +: IW];
      ci = {ci[IW-2:0], ci[IW-1]};
      ci[0] = ci[0] ^ b;
      ci[l % IW] = ci[l % IW] ^ s.ghr[l-1];
      r.idx[g*IW +: IW] = ci;
      ct = s.tag[g*TW +: TW];
      ct = {ct[TW-2:0], ct[TW-1]};
      ct[0] = ct[0] ^ b;
      ct[l % TW] = ct[l % TW] ^ s.ghr[l-1];
      r.tag[g*TW +: TW] = ct;
      c2 = s.tag2[g*T2W +: T2W];
      c2 = {c2[T2W-2:0], c2[T2W-1]};
      c2[0] = c2[0] ^ b;
      c2[l % T2W] = c2[l % T2W] ^ s.ghr[l-1];
      r.tag2[g*T2W +: T2W] = c2;
    end
    return r;
  endfunction

  assign unused_pc  = ^bus.i_pred_pc;
  assign head       = mem_q[rd_q];
  assign head_valid = (cnt_q != '0);
  assign ready      = (cnt_q != FULL);

  assign fb_any = bus.i_fb_valid & head_valid;
  assign mis    = fb_any & bus.i_fb_mispredict;
  assign pop    = fb_any & ~bus.i_fb_mispredict;
  assign push   = bus.i_pred_valid & ready &
                  ~(bus.i_fb_valid & bus.i_fb_mispredict);

  always_comb begin
    cur_d = cur_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (mis) begin
      cur_d = shift_in(head, bus.i_fb_outcome);
`ifdef TAGE_PATH_HIST_EN
      cur_d.phist = {head.phist[14:0], pcb_q[rd_q]};
`endif
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        cur_d = shift_in(cur_q, bus.i_pred_outcome);
`ifdef TAGE_PATH_HIST_EN
        cur_d.phist = {cur_q.phist[14:0], bus.i_pred_pc[2]};
`endif
        wr_d = wr_q + PW'(1);
      end
      if (pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
`ifdef TAGE_PATH_HIST_EN
        pcb_q[i] <= 1'b0;
`endif
      end
    end else begin
      cur_q <= cur_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      if (push && !mis) begin
        mem_q[wr_q] <= cur_q;
`ifdef TAGE_PATH_HIST_EN
        pcb_q[wr_q] <= bus.i_pred_pc[2];
`endif
      end
    end
  end

`ifdef SIMULATION
  always_ff @(posedge clk) begin
    if (rst_n && bus.i_fb_valid && !head_valid)
      $error("tage_history_unit: resolve with no branch in flight");
  end
`endif

  assign bus.o_pred_ready    = ready;
  assign bus.o_fb_head_valid = head_valid;
  assign bus.o_ghr           = cur_q.ghr;
  assign bus.o_csr_tag       = cur_q.tag;
  assign bus.o_csr_tag2      = cur_q.tag2;
  assign bus.o_csr_tag_feed  = head.tag;
  assign bus.o_csr_tag2_feed = head.tag2;
`ifdef TAGE_PATH_HIST_EN
  assign bus.o_csr_idx      = cur_q.idx ^ {TABLE_NUM{cur_q.phist[IW-1:0]}};
  assign bus.o_csr_idx_feed = head.idx ^ {TABLE_NUM{head.phist[IW-1:0]}};
`else
  assign bus.o_csr_idx      = cur_q.idx;
  assign bus.o_csr_idx_feed = head.idx;
`endif

endmodule

// File: tb/tb_tage_history_unit.sv
// Directed + randomized bench for tage_history_unit.
// Expected folds come from a reference GHR model and the fold definition.
module tb_tage_history_unit;
  logic clk;
  logic rst_n;
  int   tests;
  int   fails;

  logic [63:0] m_ghr;
  logic [63:0] q [$];

  tage_history_unit_if bus ();

  tage_history_unit dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] fold(logic [63:0] h, int l, int w);
    logic [15:0] r;
    r = '0;
    for (int k = 0; k < 64; k++)
      if (k < l) r[k % w] = r[k % w] ^ h[k];
    return r;
  endfunction

  function automatic logic [39:0] e_idx(logic [63:0] h);
    logic [39:0] r;
    logic [15:0] f;
    for (int g = 0; g < 4; g++) begin
      f = fold(h, 8 << g, 10);
      r[g*10 +: 10] = f[9:0];
    end
    return r;
  endfunction

  function automatic logic [35:0] e_tag(logic [63:0] h);
    logic [35:0] r;
    logic [15:0] f;
    for (int g = 0; g < 4; g++) begin
      f = fold(h, 8 << g, 9);
      r[g*9 +: 9] = f[8:0];
    end
    return r;
  endfunction

  function automatic logic [31:0] e_tag2(logic [63:0] h);
    logic [31:0] r;
    logic [15:0] f;
    for (int g = 0; g < 4; g++) begin
      f = fold(h, 8 << g, 8);
      r[g*8 +: 8] = f[7:0];
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] got,
                     input logic [255:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [63:0] h;
    chk({tag, ".ghr"}, bus.o_ghr, m_ghr);
    chk({tag, ".idx"}, bus.o_csr_idx, e_idx(m_ghr));
    chk({tag, ".tag"}, bus.o_csr_tag, e_tag(m_ghr));
    chk({tag, ".tag2"}, bus.o_csr_tag2, e_tag2(m_ghr));
    chk({tag, ".ready"}, bus.o_pred_ready, q.size() != 8);
    chk({tag, ".hv"}, bus.o_fb_head_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk({tag, ".idxf"}, bus.o_csr_idx_feed, e_idx(h));
      chk({tag, ".tagf"}, bus.o_csr_tag_feed, e_tag(h));
      chk({tag, ".tag2f"}, bus.o_csr_tag2_feed, e_tag2(h));
    end
  endtask

  task automatic idle();
    bus.i_pred_valid    = 1'b0;
    bus.i_pred_outcome  = 1'b0;
    bus.i_pred_pc       = '0;
    bus.i_fb_valid      = 1'b0;
    bus.i_fb_outcome    = 1'b0;
    bus.i_fb_mispredict = 1'b0;
  endtask

  task automatic cyc(input logic pv, input logic po, input logic fv,
                     input logic fo, input logic fm);
    logic        push, pop, mis;
    logic [63:0] h;
    int          n;
    bus.i_pred_valid    = pv;
    bus.i_pred_outcome  = po;
    bus.i_pred_pc       = $urandom;
    bus.i_fb_valid      = fv;
    bus.i_fb_outcome    = fo;
    bus.i_fb_mispredict = fm;
    n    = q.size();
    mis  = fv && fm && n > 0;
    pop  = fv && !fm && n > 0;
    push = pv && n < 8 && !(fv && fm);
    @(posedge clk);
    #1;
    if (mis) begin
      h = q[0];
      m_ghr = {h[62:0], fo};
      q.delete();
    end else begin
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back(m_ghr);
        m_ghr = {m_ghr[62:0], po};
      end
    end
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_ghr = '0;
    q.delete();
  endtask

  initial begin
    logic pv, po, fv, fo, fm;
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    idle();
    do_reset();
    check_all("reset");
    chk("reset.ghr0", bus.o_ghr, 64'h0);

    for (int i = 0; i < 8; i++) cyc(1, 1, 0, 0, 0);
    chk("t8.ghr", bus.o_ghr[7:0], 8'hFF);
    chk("t8.idx0", bus.o_csr_idx[9:0], 10'h0FF);
    chk("t8.tag2_0", bus.o_csr_tag2[7:0], 8'hFF);
    chk("full.ready", bus.o_pred_ready, 1'b0);
    check_all("t8");
    cyc(1, 1, 0, 0, 0);
    chk("full.ignored", bus.o_ghr, 64'hFF);
    cyc(0, 0, 1, 1, 0);
    chk("pop.ready", bus.o_pred_ready, 1'b1);
    cyc(1, 1, 0, 0, 0);
    chk("t9.idx0", bus.o_csr_idx[9:0], 10'h0FF);
    chk("t9.ghr", bus.o_ghr, 64'h1FF);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, 1, 1, 0);
      check_all("drain");
    end

    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.ghr", bus.o_ghr, 64'h0);
    chk("arst.idx", bus.o_csr_idx, 40'h0);
    chk("arst.tag", bus.o_csr_tag, 36'h0);
    chk("arst.tag2", bus.o_csr_tag2, 32'h0);
    chk("arst.ready", bus.o_pred_ready, 1'b1);
    chk("arst.hv", bus.o_fb_head_valid, 1'b0);
    chk("arst.idxf", bus.o_csr_idx_feed, 40'h0);
    m_ghr = '0;
    q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    cyc(1, 1, 0, 0, 0);
    for (int i = 0; i < 15; i++) begin
      cyc(1, 1, 1, 1, 0);
      check_all("t16");
    end
    chk("t16.idx1", bus.o_csr_idx[19:10], 10'h3C0);
    chk("t16.ghr", bus.o_ghr, 64'hFFFF);

    for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0);
    check_all("c4");
    cyc(1, 1, 1, 1, 0);
    check_all("pushpop");
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, 0);
    chk("pushpop.hv3", bus.o_fb_head_valid, 1'b1);
    cyc(0, 0, 1, 1, 0);
    chk("pushpop.hv4", bus.o_fb_head_valid, 1'b0);

    do_reset();
    cyc(1, 1, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
    cyc(1, 1, 0, 0, 0);
    chk("tntt.ghr", bus.o_ghr, 64'hD);
    cyc(0, 0, 1, 1, 0);
    cyc(1, 1, 1, 0, 1);
    chk("mis.ghr3", bus.o_ghr[2:0], 3'b010);
    chk("mis.drop", bus.o_ghr, 64'h2);
    chk("mis.idx0", bus.o_csr_idx[9:0], 10'h002);
    chk("mis.hv", bus.o_fb_head_valid, 1'b0);
    chk("mis.ready", bus.o_pred_ready, 1'b1);
    check_all("mis");

    for (int i = 0; i < 10000; i++) begin
      pv = 1'($urandom_range(0, 1));
      po = 1'($urandom_range(0, 1));
      fv = (q.size() != 0) && ($urandom_range(0, 1) == 1);
      fo = 1'($urandom_range(0, 1));
      fm = fv && ($urandom_range(0, 15) == 0);
      cyc(pv, po, fv, fo, fm);
      check_all("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
